// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: byte FIFO between uart_rx and uart_tx.
// Mode 0 drains the FIFO into the transmitter as fast as the busy handshake
// allows. Mode 1 re-sends the most recently received byte once every PERIOD
// cycles and leaves the FIFO to fill. Provides occupancy, sticky overflow
// and a synchronous flush.
//
// Handshake: tx_en is a one-cycle request with tx_data already valid in that
// cycle. tx_data then holds until the next request. tx_busy is honoured only
// in IDLE (before a new request) and in WAIT (before returning to IDLE). It
// is ignored in the HOLD cycle after a request, because the transmitter
// raises busy one cycle late.
module uart_echo_buffer #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16,
  parameter int CLK_HZ       = 2000000,
  parameter int PERIOD       = CLK_HZ
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic                      flush,
  input  logic [PAYLOAD_BITS-1:0]   rx_data,
  input  logic                      rx_valid,
  input  logic                      tx_busy,
  output logic [PAYLOAD_BITS-1:0]   tx_data,
  output logic                      tx_en,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int NW   = AW + 1;
  localparam int CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
  localparam logic [NW-1:0] FULL_COUNT = NW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, HOLD, WAIT} state_t;

  state_t                  state, state_next;
  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic [NW-1:0]           count;
  logic [CW-1:0]           counter;
  logic                    pending, have_last;
  logic [PAYLOAD_BITS-1:0] last_byte;

  logic tick, fifo_empty, fifo_full;
  logic push_req, push_ok, pop;
  logic start_echo, start_repeat;

  assign tick       = (counter == '0);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  // A flush in the same cycle wins over an incoming byte.
  assign push_req   = rx_valid && !flush;
  // Room is available when not full, or when the head leaves this same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign pop        = start_echo;

  assign fifo_count = count;
  // No request leaves the block while reset is applied.
  assign tx_en      = (state == SEND) && !rst;

  // Next-state and send-start decode; mode is only looked at in IDLE.
  always_comb begin
    state_next   = state;
    start_echo   = 1'b0;
    start_repeat = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy) begin
          if (!mode) begin
            if (!fifo_empty) begin
              start_echo = 1'b1;
              state_next = SEND;
            end
          end else if (pending || (tick && have_last)) begin
            start_repeat = 1'b1;
            state_next   = SEND;
          end
        end
      end
      SEND:    state_next = HOLD;
      HOLD:    state_next = WAIT;
      WAIT:    if (!tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a byte arrived with nowhere to go.
  always_ff @(posedge clk) begin
    if (rst || flush)                    overflow <= 1'b0;
    else if (push_req && fifo_full && !pop) overflow <= 1'b1;
  end

  // Remember the latest received byte, even if the FIFO dropped it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_byte <= '0;
      have_last <= 1'b0;
    end else if (flush) begin
      have_last <= 1'b0;
    end else if (rx_valid) begin
      last_byte <= rx_data;
      have_last <= 1'b1;
    end
  end

  // Free-running repeat-interval counter, shared by both modes.
  always_ff @(posedge clk) begin
    if (rst)                     counter <= '0;
    else if (counter == CNT_LAST) counter <= '0;
    else                         counter <= counter + CW'(1);
  end

  // Remember a repeat tick that could not be served; several collapse to one.
  always_ff @(posedge clk) begin
    if (rst || flush || !mode)   pending <= 1'b0;
    else if (start_repeat)       pending <= 1'b0;
    else if (tick && have_last)  pending <= 1'b1;
  end

  // Transmit byte is captured as the request is issued and held afterwards.
  always_ff @(posedge clk) begin
    if (rst)               tx_data <= '0;
    else if (start_echo)   tx_data <= mem[rd_ptr];
    else if (start_repeat) tx_data <= last_byte;
  end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Bench for uart_echo_buffer (DEPTH=4, PERIOD=10): cycle model plus directed
// literal checks, reactive transmitter-busy generator, single summary line.
module tb_uart_echo_buffer;

  localparam int PB     = 8;
  localparam int DEPTH  = 4;
  localparam int PERIOD = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          flush = 1'b0;
  logic [PB-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          tx_busy;
  logic [PB-1:0] tx_data;
  logic          tx_en;
  logic [$clog2(DEPTH):0] fifo_count;
  logic          overflow;

  logic force_busy = 1'b0;
  int   busy_len = 0;
  int   busy_cnt = 0;
  logic en_seen;
  assign tx_busy = force_busy | (busy_cnt != 0);

  int n_vec = 0;
  int n_err = 0;
  int rel = 0;
  int r;

  logic [PB-1:0] log_d[$];
  int            log_c[$];

  // Model state.
  logic [PB-1:0] exp_q[$];
  logic          m_ovf, m_have, m_pend;
  logic [PB-1:0] m_last, m_data;
  int            m_age, m_cnt;

  uart_echo_buffer #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH), .CLK_HZ(1000), .PERIOD(PERIOD)) dut (
    .clk(clk), .rst(rst), .mode(mode), .flush(flush),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_en(tx_en), .fifo_count(fifo_count), .overflow(overflow)
  );

  // Clock.
  initial forever #5 clk = ~clk;

  // Cycles since reset release; equals the repeat counter value mod PERIOD.
  initial forever begin
    @(posedge clk);
    if (rst) rel = 0;
    else     rel = rel + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", name, act, exp, rel);
    end
  endtask

  // ---------------- behavioural model ----------------
  task automatic model_reset();
    exp_q.delete();
    m_ovf = 0; m_have = 0; m_pend = 0;
    m_last = '0; m_data = '0;
    m_age = -1; m_cnt = 0;
  endtask

  // m_age: cycles since the last transmit request, -1 when free to request.
  // The transmitter is free again in the cycle after the first non-busy cycle
  // that is at least two cycles after the request.
  task automatic model_step();
    logic tck, start, rep;
    if (rst) begin
      model_reset();
      return;
    end
    tck = (m_cnt == 0);
    start = 0; rep = 0;
    if (m_age < 0 && !tx_busy) begin
      if (!mode) start = (exp_q.size() != 0);
      else begin
        start = m_pend || (tck && m_have);
        rep = start;
      end
    end
    if (start) begin
      if (mode) m_data = m_last;
      else      m_data = exp_q.pop_front();
    end
    if (start) m_age = 0;
    else if (m_age >= 0) begin
      if (m_age >= 2 && !tx_busy) m_age = -1;
      else m_age = m_age + 1;
    end
    if (flush) begin
      exp_q.delete();
      m_ovf = 0; m_have = 0; m_pend = 0;
    end else begin
      if (!mode)              m_pend = 0;
      else if (rep)           m_pend = 0;
      else if (tck && m_have) m_pend = 1;
      if (rx_valid) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(rx_data);
        else m_ovf = 1;
        m_last = rx_data;
        m_have = 1;
      end
    end
    m_cnt = (m_cnt + 1) % PERIOD;
  endtask

  // Compare process: every cycle after the first clock edge.
  initial begin
    model_reset();
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("tx_en",      32'(tx_en),      32'((m_age == 0) && !rst));
      check("tx_data",    32'(tx_data),    32'(m_data));
      check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
      check("overflow",   32'(overflow),   32'(m_ovf));
      model_step();
    end
  end

  // Transmit log for directed checks.
  initial forever begin
    @(negedge clk);
    if (tx_en === 1'b1) begin
      log_d.push_back(tx_data);
      log_c.push_back(rel);
    end
  end

  // Transmitter busy model: busy for busy_len cycles starting after a request.
  initial forever begin
    @(negedge clk);
    en_seen = tx_en;
    @(posedge clk);
    #1;
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (en_seen === 1'b1 && busy_len > 0) busy_cnt = busy_len;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [PB-1:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
  endtask

  task automatic clear_log();
    log_d.delete();
    log_c.delete();
  endtask

  task automatic align(input int ph);
    for (int i = 0; i < PERIOD && (rel % PERIOD) != ph; i++) step(1);
  endtask

  // Watchdog.
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset values.
    step(2);
    @(negedge clk);
    check("rst_tx_en",    32'(tx_en),      32'h0);
    check("rst_tx_data",  32'(tx_data),    32'h0);
    check("rst_count",    32'(fifo_count), 32'h0);
    check("rst_overflow", 32'(overflow),   32'h0);
    step(1);
    rst = 1'b0;
    step(5);

    // Echo latency: byte in N, count 1 in N+1, request in N+2.
    send_byte(8'h41);
    @(negedge clk);
    check("echo_cnt_n1", 32'(fifo_count), 32'h1);
    check("echo_en_n1",  32'(tx_en),      32'h0);
    step(1);
    @(negedge clk);
    check("echo_en_n2",   32'(tx_en),      32'h1);
    check("echo_data_n2", 32'(tx_data),    32'h41);
    check("echo_cnt_n2",  32'(fifo_count), 32'h0);
    step(5);

    // Busy handshake: three bytes, 20-cycle busy after each request.
    busy_len = 20;
    clear_log();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    step(70);
    busy_len = 0;
    check("busy_nsent", 32'(log_d.size()), 32'd3);
    if (log_d.size() == 3) begin
      check("busy_b0", 32'(log_d[0]), 32'h01);
      check("busy_b1", 32'(log_d[1]), 32'h02);
      check("busy_b2", 32'(log_d[2]), 32'h03);
      check("busy_gap01", 32'((log_c[1] - log_c[0]) >= 23), 32'h1);
      check("busy_gap12", 32'((log_c[2] - log_c[1]) >= 23), 32'h1);
    end

    // Overflow with DEPTH=4 while the transmitter is held busy.
    force_busy = 1'b1;
    clear_log();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i));
    @(negedge clk);
    check("ovf_cnt4",  32'(fifo_count), 32'd4);
    check("ovf_flag4", 32'(overflow),   32'h0);
    step(1);
    send_byte(8'h14);
    @(negedge clk);
    check("ovf_cnt5",  32'(fifo_count), 32'd4);
    check("ovf_flag5", 32'(overflow),   32'h1);
    step(1);
    send_byte(8'h15);
    force_busy = 1'b0;
    step(30);
    check("ovf_nsent", 32'(log_d.size()), 32'd4);
    if (log_d.size() == 4) begin
      for (int i = 0; i < 4; i++) check("ovf_byte", 32'(log_d[i]), 32'(8'h10 + i));
    end
    check("ovf_sticky", 32'(overflow), 32'h1);
    pulse_flush();
    @(negedge clk);
    check("flush_ovf", 32'(overflow),   32'h0);
    check("flush_cnt", 32'(fifo_count), 32'h0);
    step(1);

    // Periodic mode: byte at phase 5, repeats one cycle after each tick.
    mode = 1'b1;
    step(1);
    align(5);
    clear_log();
    send_byte(8'h5A);
    step(30);
    check("per_nsent", 32'(log_d.size()), 32'd3);
    for (int i = 0; i < log_d.size(); i++) begin
      check("per_byte",  32'(log_d[i]),          32'h5A);
      check("per_phase", 32'(log_c[i] % PERIOD), 32'd1);
    end
    check("per_cnt", 32'(fifo_count), 32'd1);
    clear_log();
    mode = 1'b0;
    step(10);
    check("m0_nsent", 32'(log_d.size()), 32'd1);
    if (log_d.size() == 1) check("m0_byte", 32'(log_d[0]), 32'h5A);
    check("m0_cnt", 32'(fifo_count), 32'd0);

    // Missed ticks collapse into one send, then the schedule resumes.
    mode = 1'b1;
    force_busy = 1'b1;
    send_byte(8'h33);
    step(35);
    align(5);
    r = rel;
    clear_log();
    force_busy = 1'b0;
    step(21);
    check("miss_nsent", 32'(log_d.size()), 32'd3);
    if (log_d.size() == 3) begin
      check("miss_first", 32'(log_c[0]), 32'(r + 1));
      check("miss_second", 32'(log_c[1]), 32'(r + 6));
      check("miss_third", 32'(log_c[2]), 32'(r + 16));
      check("miss_byte", 32'(log_d[0]), 32'h33);
    end

    // Flush and rx_valid together: byte discarded, nothing to repeat.
    mode = 1'b0;
    step(10);
    clear_log();
    rx_data = 8'h77;
    rx_valid = 1'b1;
    flush = 1'b1;
    step(1);
    rx_valid = 1'b0;
    flush = 1'b0;
    step(20);
    check("fl_rx_nsent", 32'(log_d.size()), 32'd0);
    check("fl_rx_cnt",   32'(fifo_count),   32'd0);
    mode = 1'b1;
    step(25);
    check("fl_rx_norep", 32'(log_d.size()), 32'd0);
    mode = 1'b0;
    step(2);

    // Reset during WAIT, then mode-1 ticks have nothing to send.
    busy_len = 20;
    clear_log();
    send_byte(8'hAB);
    step(4);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_en", 32'(tx_en), 32'h0);
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("rstw_cnt", 32'(fifo_count), 32'h0);
    check("rstw_data", 32'(tx_data), 32'h0);
    step(1);
    busy_len = 0;
    mode = 1'b1;
    step(25);
    check("rstw_nsent", 32'(log_d.size()), 32'd1);
    mode = 1'b0;
    step(20);

    // Reset in the request cycle suppresses the pulse.
    clear_log();
    send_byte(8'hCD);
    step(1);
    rst = 1'b1;
    @(negedge clk);
    check("rsts_en", 32'(tx_en), 32'h0);
    step(1);
    rst = 1'b0;
    step(5);
    check("rsts_nsent", 32'(log_d.size()), 32'd0);
    check("rsts_cnt",   32'(fifo_count),   32'd0);

    // Echo still works after reset.
    send_byte(8'h99);
    step(1);
    @(negedge clk);
    check("post_en",   32'(tx_en),   32'h1);
    check("post_data", 32'(tx_data), 32'h99);
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_echo_buffer.md
Name: uart_echo_buffer

Overview:
- Buffered, parametrised successor to the single-byte UART loopback register.
- Sits between the uart_rx and uart_tx instances in the toplevel.
- Queues received bytes in a FIFO and drives the transmitter with a busy-aware handshake.
- Two modes: immediate echo (FIFO drain), or periodic repeat of the last received byte every PERIOD cycles.
- Adds occupancy reporting, sticky overflow detection and flush.

Parameters:
- PAYLOAD_BITS, 8: data width of rx and tx bytes.
- DEPTH, 16: FIFO entries; power of two, ≥2.
- CLK_HZ, 2000000: system clock frequency; used only as the PERIOD default.
- PERIOD, CLK_HZ: repeat interval in cycles for mode 1; must be ≥4.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- mode, in, 1: 0 = echo (drain FIFO), 1 = periodic repeat of last byte.
- flush, in, 1: synchronous FIFO/state clear, single-cycle pulse.
- rx_data, in, PAYLOAD_BITS: byte from the receiver.
- rx_valid, in, 1: one-cycle strobe qualifying rx_data.
- tx_busy, in, 1: transmitter busy.
- tx_data, out, PAYLOAD_BITS: byte to the transmitter; held stable from the SEND cycle until the next SEND.
- tx_en, out, 1: one-cycle transmit request.
- fifo_count, out, $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- overflow, out, 1: sticky, set when a byte is dropped.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; FIFO empty; counter=0; pending=0; have_last=0; last_byte=0. Outputs: tx_en=0, tx_data=0, fifo_count=0, overflow=0.
- FIFO push: on rx_valid, rx_data is written. The push is accepted if not full, or if a pop occurs in the same cycle.
- FIFO full, no pop, rx_valid=1: the byte is dropped, count is unchanged, overflow←1.
- Simultaneous push and pop: count is unchanged. Read and write pointers wrap modulo DEPTH.
- last_byte/have_last: last_byte←rx_data and have_last←1 on every rx_valid, in both modes, including when the byte is dropped for overflow.
- Period counter: free-runs 0..PERIOD-1 then wraps to 0 in both modes; tick = (counter==0).
- pending: in mode 1, set on tick when have_last=1; cleared when a mode-1 send starts; forced to 0 whenever mode=0.
- State machine:
  - IDLE to SEND, mode 0: when FIFO non-empty and tx_busy=0. At that edge, tx_data←head and the head is popped.
  - IDLE to SEND, mode 1: when (pending or tick-with-have_last) and tx_busy=0. At that edge, tx_data←last_byte and pending←0. The FIFO is not popped in mode 1; it only fills.
  - SEND: tx_en=1 for exactly this cycle; always go to HOLD.
  - HOLD: one cycle, tx_busy ignored, to cover transmitter busy lag; then go to WAIT.
  - WAIT: go to IDLE when tx_busy=0.
  - tx_en is 1 only in SEND, so there is never more than one pulse per 3 cycles.
- Echo latency: rx_valid in cycle N with FIFO empty, IDLE, tx_busy=0 → fifo_count=1 in N+1 → tx_en=1 with tx_data=byte in N+2 → fifo_count=0 in N+2.
- Tick during SEND/HOLD/WAIT: recorded via pending and served on the next IDLE. Multiple missed ticks collapse into one send.
- Mode change: sampled only in IDLE; an in-flight transmission always completes. Switching 1→0 begins draining the bytes accumulated in the FIFO.
- Flush, synchronous:
  - Empties the FIFO and clears pending, have_last and overflow.
  - Does not abort SEND/HOLD/WAIT.
  - flush and rx_valid in the same cycle: flush wins and the byte is discarded, not recorded in last_byte.
- rst mid-operation: immediate return to reset values. A tx_en pulse that would have occurred in the reset cycle is suppressed.

Test Plan:
- Echo latency: mode=0, tx_busy=0, rx_valid with 0x41 at cycle 10 → tx_en=1 and tx_data=0x41 exactly at cycle 12; fifo_count shows 1 at cycle 11 and 0 at cycle 12.
- Busy handshake: push 0x01,0x02,0x03; model busy high for 20 cycles starting the cycle after each tx_en → three tx_en pulses in order 0x01,0x02,0x03; no pulse while busy=1; pulses ≥23 cycles apart.
- Overflow: DEPTH=4, tx_busy held 1, push 6 bytes 0x10..0x15 → fifo_count=4, overflow=1 after the 5th; release busy → 0x10..0x13 sent only. Then flush → overflow=0, fifo_count=0.
- Periodic mode: PERIOD=100, mode=1, push 0x5A at cycle 5 → tx_en with 0x5A at every tick (counter==0) plus 1 cycle (cycles 101, 201, …); fifo_count=1, never drained. Switch mode to 0 → 0x5A echoed once from the FIFO.
- Missed ticks: mode=1, PERIOD=10, tx_busy held 1 for 35 cycles → exactly one tx_en after busy drops, then resumes on the tick schedule.
- Simultaneous events: flush and rx_valid(0x77) in the same cycle → no tx_en ever, fifo_count=0. rst asserted during WAIT → tx_en=0, fifo_count=0, and mode-1 ticks send nothing until a new rx_valid.
